// File: rtl/pixel_proc_pipe.sv
// 3x3-window pixel processor: frame FSM plus a two-stage handshake pipeline (S1 window, S2 result).
// Optional grayscale pre-conversion is compiled in with `define PIXEL_PROC_GRAY_EN (NCH=3 only).
module pixel_proc_pipe #(
    parameter int CH_W  = 4,
    parameter int NCH   = 3,
    parameter int CNT_W = 20
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [2:0]              func,
    input  logic                    gray,
    input  logic [CNT_W-1:0]        npix,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [3*CH_W*NCH-1:0]   row0,
    input  logic [3*CH_W*NCH-1:0]   row1,
    input  logic [3*CH_W*NCH-1:0]   row2,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CH_W*NCH-1:0]     data_out,
    output logic                    busy,
    output logic                    done
);
    localparam int PIX_W = CH_W * NCH;
    localparam int SW    = CH_W + 6;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef logic signed [SW-1:0] sval_t;
    localparam sval_t MAXV = sval_t'((1 << CH_W) - 1);
    localparam sval_t QTR  = sval_t'(1 << (CH_W - 2));
    localparam sval_t HALF = sval_t'(1 << (CH_W - 1));

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t             state_reg, state_next;
    logic [2:0]         func_reg;
    logic [CNT_W-1:0]   npix_reg;
    logic [CNT_W-1:0]   in_cnt_reg;
    logic [CNT_W-1:0]   out_cnt_reg;

    logic               s1_valid_reg;
    logic [PIX_W-1:0]   s1_win_reg [9];
    logic               s2_valid_reg;
    logic [PIX_W-1:0]   s2_data_reg;

    logic [PIX_W-1:0]   win_in  [9];
    logic [PIX_W-1:0]   win_pre [9];
    logic [PIX_W-1:0]   result;

    logic               s2_adv;
    logic               s1_load;
    logic               in_fire;
    logic               out_fire;

    function automatic logic [CH_W-1:0] clamp(input sval_t v);
        if (v[SW-1])
            clamp = '0;
        else if (v > MAXV)
            clamp = '1;
        else
            clamp = v[CH_W-1:0];
    endfunction

    // Window pixel index k = row*3 + column; index 4 is the centre.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_unpack
            assign win_in[gi]     = row0[gi*PIX_W +: PIX_W];
            assign win_in[3 + gi] = row1[gi*PIX_W +: PIX_W];
            assign win_in[6 + gi] = row2[gi*PIX_W +: PIX_W];
        end
    endgenerate

`ifdef PIXEL_PROC_GRAY_EN
    logic gray_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            gray_reg <= 1'b0;
        else if (state_reg == IDLE && start)
            gray_reg <= gray;
    end

    generate
        if (NCH == 3) begin : g_gray
            for (gi = 0; gi < 9; gi++) begin : g_pix
                logic [CH_W+1:0] gsum;
                assign gsum = {2'b00, win_in[gi][3*CH_W-1:2*CH_W]}
                            + {1'b0, win_in[gi][2*CH_W-1:CH_W], 1'b0}
                            + {2'b00, win_in[gi][CH_W-1:0]};
                assign win_pre[gi] = gray_reg ? {3{gsum[CH_W+1:2]}} : win_in[gi];
            end
        end else begin : g_nogray
            logic unused_gray;
            assign unused_gray = gray_reg;
            for (gi = 0; gi < 9; gi++) begin : g_pix
                assign win_pre[gi] = win_in[gi];
            end
        end
    endgenerate
`else
    logic unused_gray;
    assign unused_gray = gray;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_pix
            assign win_pre[gi] = win_in[gi];
        end
    endgenerate
`endif

    assign s2_adv   = !s2_valid_reg || out_ready;
    assign s1_load  = !s1_valid_reg || s2_adv;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = s2_valid_reg && out_ready;

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start)
                    state_next = (npix == '0) ? DONE : RUN;
            end
            RUN: begin
                busy     = 1'b1;
                in_ready = s1_load;
                if (in_fire && (in_cnt_reg + CNT_ONE == npix_reg))
                    state_next = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (out_fire && (out_cnt_reg + CNT_ONE == npix_reg))
                    state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            func_reg    <= '0;
            npix_reg    <= '0;
            in_cnt_reg  <= '0;
            out_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && start) begin
                func_reg    <= func;
                npix_reg    <= npix;
                in_cnt_reg  <= '0;
                out_cnt_reg <= '0;
            end else begin
                if (in_fire)
                    in_cnt_reg <= in_cnt_reg + CNT_ONE;
                if (out_fire)
                    out_cnt_reg <= out_cnt_reg + CNT_ONE;
            end
        end
    end

    // Per-channel kernel evaluation on the S1 window; all terms are non-negative
    // CH_W-bit values widened to SW signed bits so no step can overflow.
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            sval_t           p [9];
            sval_t           acc;
            logic [CH_W-1:0] res_ch;

            for (genvar gk = 0; gk < 9; gk++) begin : g_tap
                assign p[gk] = $signed({6'b000000, s1_win_reg[gk][gi*CH_W +: CH_W]});
            end

            always_comb begin
                acc = p[4];
                case (func_reg)
                    3'd0: acc = p[4];
                    3'd1: acc = MAXV - p[4];
                    3'd2: acc = p[4] + QTR;
                    3'd3: acc = (p[4] >= HALF) ? MAXV : '0;
                    3'd4: acc = (p[0] + p[2] + p[6] + p[8]
                                 + ((p[1] + p[3] + p[5] + p[7]) <<< 1)
                                 + (p[4] <<< 2)) >>> 4;
                    3'd5: acc = (p[4] <<< 2) + p[4] - p[1] - p[7] - p[3] - p[5];
                    3'd6: begin
                        acc = (p[4] <<< 3) - (p[0] + p[1] + p[2] + p[3]
                                              + p[5] + p[6] + p[7] + p[8]);
                        if (acc[SW-1])
                            acc = -acc;
                    end
                    3'd7: acc = p[4] + p[0] - p[8];
                    default: acc = p[4];
                endcase
                res_ch = clamp(acc);
            end

            assign result[gi*CH_W +: CH_W] = res_ch;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s2_valid_reg <= 1'b0;
            s2_data_reg  <= '0;
            for (int k = 0; k < 9; k++)
                s1_win_reg[k] <= '0;
        end else begin
            if (s1_load) begin
                s1_valid_reg <= in_fire;
                if (in_fire)
                    for (int k = 0; k < 9; k++)
                        s1_win_reg[k] <= win_pre[k];
            end
            // data_out only changes when S2 accepts a new pixel, so a stall holds it.
            if (s2_adv) begin
                s2_valid_reg <= s1_valid_reg;
                if (s1_valid_reg)
                    s2_data_reg <= result;
            end
        end
    end

    assign out_valid = s2_valid_reg;
    assign data_out  = s2_data_reg;

endmodule

// File: tb/tb_pixel_proc_pipe.sv
// Self-checking bench for pixel_proc_pipe (CH_W=4, NCH=3) with a per-pixel arithmetic reference model.
module tb_pixel_proc_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  func = '0;
    logic        gray = 1'b0;
    logic [19:0] npix = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [35:0] row0 = '0, row1 = '0, row2 = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [11:0] data_out;
    logic        busy, done;

    int errors = 0;
    int checks = 0;

`ifdef PIXEL_PROC_GRAY_EN
    localparam bit GRAY_BUILT = 1'b1;
`else
    localparam bit GRAY_BUILT = 1'b0;
`endif

    pixel_proc_pipe #(.CH_W(4), .NCH(3), .CNT_W(20)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .func(func), .gray(gray), .npix(npix),
        .in_valid(in_valid), .in_ready(in_ready), .row0(row0), .row1(row1), .row2(row2),
        .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [35:0] w0 [$];
    logic [35:0] w1 [$];
    logic [35:0] w2 [$];

    int          st_nout, st_first_acc, st_first_ov, st_last_out, st_done_cyc, st_done_cnt, st_stall_acc;
    logic [11:0] st_last_data;

    function automatic logic [11:0] model(input int f, input bit g, input logic [35:0] r0, r1, r2);
        int p [9][3];
        int x, v, s;
        logic [107:0] all;
        logic [11:0]  res;
        all = {r2, r1, r0};
        for (int k = 0; k < 9; k++)
            for (int c = 0; c < 3; c++)
                p[k][c] = int'(all[k*12 + c*4 +: 4]);
        if (g && GRAY_BUILT)
            for (int k = 0; k < 9; k++) begin
                s = (p[k][2] + 2 * p[k][1] + p[k][0]) / 4;
                for (int c = 0; c < 3; c++) p[k][c] = s;
            end
        res = '0;
        for (int c = 0; c < 3; c++) begin
            x = p[4][c];
            case (f)
                0: v = x;
                1: v = 15 - x;
                2: v = x + 4;
                3: v = (x >= 8) ? 15 : 0;
                4: v = (p[0][c] + 2*p[1][c] + p[2][c] + 2*p[3][c] + 4*x
                        + 2*p[5][c] + p[6][c] + 2*p[7][c] + p[8][c]) / 16;
                5: v = 5*x - p[1][c] - p[7][c] - p[3][c] - p[5][c];
                6: begin
                    s = 0;
                    for (int k = 0; k < 9; k++) if (k != 4) s += p[k][c];
                    v = 8*x - s;
                    if (v < 0) v = -v;
                end
                default: v = x + p[0][c] - p[8][c];
            endcase
            if (v < 0) v = 0;
            if (v > 15) v = 15;
            res[c*4 +: 4] = 4'(v);
        end
        return res;
    endfunction

    function automatic logic [35:0] rnd36();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[35:0];
    endfunction

    task automatic clear_windows();
        w0.delete(); w1.delete(); w2.delete();
    endtask

    task automatic add_window(input logic [35:0] a, b, c);
        w0.push_back(a); w1.push_back(b); w2.push_back(c);
    endtask

    // Drive one frame from the w0/w1/w2 queues; outputs are checked against the model in order.
    // ready_mode: 0 always ready, 1 stalled for cycles 0..4, 2 random.
    task automatic run_frame(input int f, input bit g, input int n, input int ready_mode,
                             input bit rnd_valid, input int restart_cyc, input int abort_after);
        int cyc, ai, oi;
        bit prev_stall;
        logic [11:0] prev_data, exp;
        st_nout = 0; st_first_acc = -1; st_first_ov = -1; st_last_out = -1;
        st_done_cyc = -1; st_done_cnt = 0; st_stall_acc = -1; st_last_data = '0;
        @(negedge clk);
        start = 1'b1; func = 3'(f); gray = g; npix = 20'(n); in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        cyc = 0; ai = 0; oi = 0; prev_stall = 1'b0; prev_data = '0;
        while (cyc < 2000) begin
            in_valid = (ai < n) && (!rnd_valid || ($urandom_range(0, 1) == 1));
            if (ai < n) begin row0 = w0[ai]; row1 = w1[ai]; row2 = w2[ai]; end
            case (ready_mode)
                1:       out_ready = (cyc >= 5);
                2:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b1;
            endcase
            start = (cyc == restart_cyc);
            if (start) begin npix = 20'd1; func = 3'd1; end
            #1;
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || data_out !== prev_data) begin
                    errors++;
                    $display("FAIL stall_hold: got valid=%b data=%h, need valid=1 data=%h", out_valid, data_out, prev_data);
                end
            end
            if (done === 1'b1) begin
                if (st_done_cyc < 0) st_done_cyc = cyc;
                st_done_cnt++;
            end
            if (out_valid === 1'b1 && st_first_ov < 0) st_first_ov = cyc;
            if (out_valid === 1'b1 && out_ready) begin
                checks++;
                if (oi >= n) begin
                    errors++;
                    $display("FAIL extra_output: got pixel %0d data=%h, need only %0d pixels", oi, data_out, n);
                end else begin
                    exp = model(f, g, w0[oi], w1[oi], w2[oi]);
                    if (data_out !== exp) begin
                        errors++;
                        $display("FAIL pixel_%0d func=%0d: got %h, need %h", oi, f, data_out, exp);
                    end
                end
                oi++; st_nout = oi; st_last_out = cyc; st_last_data = data_out;
            end
            if (in_valid && in_ready === 1'b1) begin
                if (st_first_acc < 0) st_first_acc = cyc;
                ai++;
            end
            if (ready_mode == 1 && cyc == 4) st_stall_acc = ai;
            prev_stall = (out_valid === 1'b1) && !out_ready;
            prev_data  = data_out;
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (abort_after > 0 && oi == abort_after) break;
            if (st_done_cyc >= 0 && cyc > st_done_cyc + 2) break;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        if (abort_after == 0 && st_done_cyc < 0) begin
            checks++; errors++;
            $display("FAIL timeout: got no done within %0d cycles, need done", cyc);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL reset_in_ready: got %b need 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b need 0", out_valid); end
        checks++; if (data_out !== 12'h0) begin errors++; $display("FAIL reset_data: got %h need 000", data_out); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done: got %b%b need 00", busy, done); end
        @(negedge clk);
        rst_n = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_pass_seq();
        clear_windows();
        for (int i = 0; i < 4; i++)
            add_window(rnd36(), {rnd36()[35:24], 12'h123 + 12'(i), rnd36()[11:0]}, rnd36());
        run_frame(0, 0, 4, 0, 0, -1, 0);
        checks++; if (st_nout != 4) begin errors++; $display("FAIL pass_count: got %0d need 4", st_nout); end
        checks++; if (st_last_data !== 12'h126) begin errors++; $display("FAIL pass_last: got %h need 126", st_last_data); end
        checks++; if (st_first_ov - st_first_acc != 2) begin errors++; $display("FAIL latency: got %0d need 2", st_first_ov - st_first_acc); end
        checks++; if (st_done_cyc - st_last_out != 1) begin errors++; $display("FAIL done_timing: got %0d need 1", st_done_cyc - st_last_out); end
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b need 0", busy); end
        $display("test_pass_seq: %0d outputs, latency %0d", st_nout, st_first_ov - st_first_acc);
    endtask

    task automatic test_kernels();
        clear_windows(); add_window(36'hFFFFFFFFF, 36'hFFFFFFFFF, 36'hFFFFFFFFF);
        run_frame(4, 0, 1, 0, 0, -1, 0);
        checks++; if (st_last_data !== 12'hFFF) begin errors++; $display("FAIL gaussian_max: got %h need FFF", st_last_data); end
        clear_windows(); add_window(36'h0, 36'h000FFF000, 36'h0);
        run_frame(5, 0, 1, 0, 0, -1, 0);
        checks++; if (st_last_data !== 12'hFFF) begin errors++; $display("FAIL sharpen_clamp: got %h need FFF", st_last_data); end
        clear_windows(); add_window(36'h0, 36'h000111000, 36'h0);
        run_frame(6, 0, 1, 0, 0, -1, 0);
        checks++; if (st_last_data !== 12'h888) begin errors++; $display("FAIL edge_point: got %h need 888", st_last_data); end
        $display("test_kernels done");
    endtask

    task automatic test_random_funcs();
        for (int f = 0; f < 8; f++) begin
            clear_windows();
            for (int i = 0; i < 6; i++) add_window(rnd36(), rnd36(), rnd36());
            run_frame(f, 0, 6, 2, 1, -1, 0);
            checks++; if (st_nout != 6) begin errors++; $display("FAIL random_count_f%0d: got %0d need 6", f, st_nout); end
            $display("test_random_funcs: func=%0d outputs=%0d", f, st_nout);
        end
    endtask

    task automatic test_back_to_back_stall();
        clear_windows();
        for (int i = 0; i < 6; i++) add_window(rnd36(), rnd36(), rnd36());
        run_frame(2, 0, 6, 1, 0, -1, 0);
        checks++; if (st_stall_acc != 2) begin errors++; $display("FAIL stall_accepts: got %0d need 2", st_stall_acc); end
        checks++; if (st_nout != 6) begin errors++; $display("FAIL stall_count: got %0d need 6", st_nout); end
        $display("test_back_to_back_stall: accepts during stall=%0d", st_stall_acc);
    endtask

    task automatic test_gray();
        logic [11:0] want;
        want = GRAY_BUILT ? 12'h333 : 12'hF00;
        clear_windows(); add_window(rnd36(), {rnd36()[35:24], 12'hF00, rnd36()[11:0]}, rnd36());
        run_frame(0, 1, 1, 0, 0, -1, 0);
        checks++; if (st_last_data !== want) begin errors++; $display("FAIL gray_centre: got %h need %h", st_last_data, want); end
        $display("test_gray: data=%h", st_last_data);
    endtask

    task automatic test_npix_zero_and_restart();
        clear_windows();
        run_frame(0, 0, 0, 0, 0, -1, 0);
        checks++; if (st_done_cyc != 0) begin errors++; $display("FAIL zero_done_cycle: got %0d need 0", st_done_cyc); end
        checks++; if (st_first_ov != -1 || st_done_cnt != 1) begin errors++; $display("FAIL zero_outputs: got ov_cycle=%0d done_cnt=%0d need -1/1", st_first_ov, st_done_cnt); end
        clear_windows();
        for (int i = 0; i < 4; i++) add_window(rnd36(), rnd36(), rnd36());
        run_frame(0, 0, 4, 0, 0, 2, 0);
        checks++; if (st_nout != 4 || st_done_cnt != 1) begin errors++; $display("FAIL restart_ignored: got outputs=%0d done_cnt=%0d need 4/1", st_nout, st_done_cnt); end
        $display("test_npix_zero_and_restart done");
    endtask

    task automatic test_reset_mid();
        bit saw_done;
        clear_windows();
        for (int i = 0; i < 8; i++) add_window(rnd36(), rnd36(), rnd36());
        run_frame(7, 0, 8, 0, 0, -1, 2);
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL midreset_handshake: got ov=%b ir=%b need 0/0", out_valid, in_ready); end
        checks++; if (data_out !== 12'h0 || busy !== 1'b0) begin errors++; $display("FAIL midreset_data: got %h busy=%b need 000/0", data_out, busy); end
        saw_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            if (done === 1'b1) saw_done = 1'b1;
        end
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            if (done === 1'b1) saw_done = 1'b1;
        end
        checks++; if (saw_done) begin errors++; $display("FAIL midreset_done: got done pulse, need none"); end
        clear_windows();
        for (int i = 0; i < 3; i++) add_window(rnd36(), rnd36(), rnd36());
        run_frame(3, 0, 3, 0, 0, -1, 0);
        checks++; if (st_nout != 3 || st_done_cnt != 1) begin errors++; $display("FAIL after_reset_frame: got outputs=%0d done_cnt=%0d need 3/1", st_nout, st_done_cnt); end
        $display("test_reset_mid: new frame outputs=%0d", st_nout);
    endtask

    initial begin
        test_reset();
        test_pass_seq();
        test_kernels();
        test_random_funcs();
        test_back_to_back_stall();
        test_gray();
        test_npix_zero_and_restart();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
